// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder used by the serial datapath.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add (and optionally subtract), LSB first, one bit per clock.
// Subtraction and the sub port are present only when SERIAL_ADDER_SUB_EN is defined.
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | one operand bit processed per edge
// DONE  | result valid, single-cycle done pulse
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             sub_eff;
  logic             accept, last_bit;
  logic             fa_s, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (bit_cnt == CNT_W'(WIDTH - 1));

  adder_1bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // Working registers shift during RUN; outputs only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= sub_eff ? ~b : b;
      carry   <= sub_eff;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
      carry   <= fa_c;
      bit_cnt <= bit_cnt + 1'b1;
      if (last_bit) begin
        sum  <= {fa_s, res_sr[WIDTH-1:1]};
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; accepted only when ready=1.
REQ-005 a  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 b  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 sub  input  1  1 = A-B, 0 = A+B, sampled on the accepting edge (present only with SERIAL_ADDER_SUB_EN).
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high in RUN only.
REQ-010 done  output  1  one-cycle pulse, high in DONE only.
REQ-011 sum  output  WIDTH  result, valid from done onward, held until next accepted start.
REQ-012 cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-013 ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start&ready; RUN->DONE after WIDTH RUN edges; DONE->IDLE unconditionally next edge.
REQ-015 Accepting edge: load A shift reg = a, B shift reg = b (or ~b when sub=1), carry reg = sub (0 when add), bit counter = 0.
REQ-016 Each RUN edge: one full-add of A[0], B[0], carry; sum bit shifted into result MSB end, A/B shifted right by one, carry reg updated, counter +1.
REQ-017 Processing LSB first; after WIDTH RUN edges result register holds full sum in correct bit order.
REQ-018 Latency: done high in the cycle after the WIDTH-th RUN edge, i.e. WIDTH edges after the accepting edge; throughput one operation per WIDTH+2 cycles.
REQ-019 Carry into MSB captured on the final RUN edge for ovf; cout = final carry reg.
REQ-020 start while busy or done: ignored, no effect on state or operands.
REQ-021 sum/cout/ovf unchanged during RUN (internal result register separate from output holding register), updated on the edge entering DONE.
REQ-022 Counter width = clog2(WIDTH)+1; no wrap within an operation.

Reset
REQ-023 rst=1 at any edge: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, counter/carry/shift regs=0.
REQ-024 rst mid-RUN abandons operation; no done pulse produced for it.
REQ-025 rst has priority over start on the same edge.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN defined: sub port exists, subtraction per REQ-015.
REQ-027 Macro undefined: no sub port, B loaded unmodified, carry-in 0, add only; all other behaviour identical.

Structure
REQ-028 Package serial_adder_pkg holds FSM state typedef (IDLE/RUN/DONE) and default WIDTH constant.
REQ-029 Per-bit arithmetic uses one instance of existing codebase sub-module adder_1bit; no other sub-modules.

Verification (WIDTH=8)
REQ-030 add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1, done exactly 8 edges after accepting edge.
REQ-031 add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
REQ-032 sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-033 start with a=0x11 asserted during RUN of 0x22+0x33 -> ignored, result 0x55, single done pulse.
REQ-034 rst asserted at 4th RUN edge -> all outputs 0, ready=1 next cycle, no done; new start 0x01+0x02 -> 0x03.
REQ-035 back-to-back: start held high continuously -> operations accepted every 10 cycles, each with one done pulse.
